// File: rtl/ifm_bank_reader_if.sv
// ifm_bank_reader_if
// Word stream from the IFM bank reader to the next layer's compute input.
//   o_data : head word of the reader's output FIFO
//   o_vld  : o_data is valid
//   o_last : final word of the burst, qualified by o_vld
//   i_rdy  : consumer ready; a word transfers when o_vld & i_rdy
// Modports: master = reader side, slave = consumer side.
interface ifm_bank_reader_if #(
    parameter int DATA_W = 128
) ();
    logic [DATA_W-1:0] o_data;
    logic              o_vld;
    logic              o_last;
    logic              i_rdy;

    modport master (output o_data, output o_vld, output o_last, input i_rdy);
    modport slave  (input o_data, input o_vld, input o_last, output i_rdy);
endinterface

// File: rtl/ifm_bank_reader.sv
// ifm_bank_reader
// Reads the feature-map SRAM banks back one word at a time, round-robin over
// banks 0..NUM_BANKS-1 at each address, and streams the words out through a
// 2-entry FIFO that absorbs the 1-cycle SRAM read latency.
// Ports:
//   clk, rstn    : clock (rising edge), asynchronous active-low reset
//   i_start      : one-cycle burst start pulse, honoured only when idle
//   i_base_addr  : first bank address, sampled with i_start
//   i_num_addr   : addresses per bank, sampled with i_start
//   o_cs         : one-hot bank read chip-select
//   o_addr       : read address shared by all banks
//   i_rdata      : packed bank read data, bank k at [k*DATA_W +: DATA_W]
//   stream       : output word stream (o_data/o_vld/o_last/i_rdy)
//   o_busy       : burst in progress, up to and including the o_done cycle
//   o_done       : one-cycle burst-complete pulse
module ifm_bank_reader #(
    parameter int NUM_BANKS = 16,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 128,
    parameter int CNT_W     = 11
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_start,
    input  logic [ADDR_W-1:0]           i_base_addr,
    input  logic [CNT_W-1:0]            i_num_addr,
    output logic [NUM_BANKS-1:0]        o_cs,
    output logic [ADDR_W-1:0]           o_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] i_rdata,
    ifm_bank_reader_if.master           stream,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [CNT_W-1:0]  addr_left;
    logic [BANK_W-1:0] bank_idx;
    logic [BANK_W-1:0] bank_d;
    logic              inflight;
    logic              last_d;

    logic [DATA_W-1:0] mem_data [2];
    logic              mem_last [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              issue;
    logic              final_issue;
    logic              bank_wrap;
    logic              push;
    logic              pop;
    logic [2:0]        occ;
    logic [2:0]        lim;

    assign push = inflight;
    assign pop  = stream.o_vld & stream.i_rdy;

    // Issue when FIFO occupancy plus the read in flight, after this cycle's
    // pop, leaves room; written as occ < 2 + pop to stay unsigned.
    assign occ   = {1'b0, count} + {2'b00, inflight};
    assign lim   = 3'd2 + {2'b00, pop};
    assign issue = (state == READ) && (occ < lim);

    assign bank_wrap   = (bank_idx == BANK_W'(NUM_BANKS - 1));
    assign final_issue = bank_wrap && (addr_left == CNT_W'(1));

    always_comb begin
        o_cs = '0;
        if (issue) begin
            o_cs[bank_idx] = 1'b1;
        end
    end

    // Address is live only on issue cycles; otherwise the last one is held.
    assign o_addr = issue ? addr_cnt : addr_hold;

    assign stream.o_vld  = (count != 2'd0);
    assign stream.o_data = mem_data[rd_ptr];
    assign stream.o_last = mem_last[rd_ptr];

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = (i_num_addr == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue && final_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && stream.o_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read counters and the one-cycle read-latency pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_cnt  <= '0;
            addr_hold <= '0;
            addr_left <= '0;
            bank_idx  <= '0;
            bank_d    <= '0;
            inflight  <= 1'b0;
            last_d    <= 1'b0;
        end else begin
            inflight <= issue;
            last_d   <= issue && final_issue;
            bank_d   <= bank_idx;
            if (state == IDLE && i_start) begin
                addr_cnt  <= i_base_addr;
                addr_left <= i_num_addr;
                bank_idx  <= '0;
            end else if (issue) begin
                addr_hold <= addr_cnt;
                if (bank_wrap) begin
                    bank_idx  <= '0;
                    addr_cnt  <= addr_cnt + 1'b1;
                    addr_left <= addr_left - 1'b1;
                end else begin
                    bank_idx <= bank_idx + 1'b1;
                end
            end
        end
    end

    // 2-entry output FIFO; the issue rule guarantees no push into a full FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last[0] <= 1'b0;
            mem_last[1] <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= i_rdata[bank_d*DATA_W +: DATA_W];
                mem_last[wr_ptr] <= last_d;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_ifm_bank_reader.sv
// tb_ifm_bank_reader
// Directed bench for ifm_bank_reader: a registered SRAM model returns a
// unique word per (bank, address); a negedge monitor logs chip-selects and
// transferred words, which are then compared against hand-derived sequences.
module tb_ifm_bank_reader;
    localparam int NB = 16;
    localparam int AW = 10;
    localparam int DW = 128;
    localparam int CW = 11;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           i_start = 1'b0;
    logic [AW-1:0]  i_base_addr = '0;
    logic [CW-1:0]  i_num_addr = '0;
    logic [NB-1:0]  o_cs;
    logic [AW-1:0]  o_addr;
    logic [NB*DW-1:0] i_rdata = '0;
    logic           o_busy;
    logic           o_done;

    ifm_bank_reader_if #(.DATA_W(DW)) stream ();

    ifm_bank_reader #(
        .NUM_BANKS(NB),
        .ADDR_W(AW),
        .DATA_W(DW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_start(i_start),
        .i_base_addr(i_base_addr),
        .i_num_addr(i_num_addr),
        .o_cs(o_cs),
        .o_addr(o_addr),
        .i_rdata(i_rdata),
        .stream(stream),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int k, input int a);
        logic [63:0] mix;
        mix = 64'h0055_AA12_3456_789A ^ 64'(a * k + 3);
        return {8'(k), 6'd0, 10'(a), 16'hC0DE, 32'(k * 1031 + a * 7), mix[55:0]};
    endfunction

    // SRAM model: data for the selected bank/address is valid the next cycle.
    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (o_cs[k]) i_rdata[k*DW +: DW] <= exp_word(k, int'(o_addr));
        end
    end

    int cyc = 0;
    int start_cyc = 0;
    int rdy_mode = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Consumer ready: 0 = always ready, 1 = ~30% stalls, 2 = never ready.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: stream.i_rdy = 1'b1;
            1: stream.i_rdy = ($urandom_range(0, 9) >= 3);
            default: stream.i_rdy = 1'b0;
        endcase
    end

    logic [NB-1:0] cs_q [$];
    logic [AW-1:0] ad_q [$];
    int            cr_q [$];
    logic [DW-1:0] dq [$];
    logic          lq [$];
    int            dr_q [$];
    int            done_cnt = 0;
    int            done_rel = -1;
    int            issued = 0;
    int            popped = 0;

    initial begin : monitor
        logic stall_prev;
        logic [DW-1:0] held;
        int rel;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                rel = cyc - start_cyc;
                if (o_cs != '0) begin
                    cs_q.push_back(o_cs);
                    ad_q.push_back(o_addr);
                    cr_q.push_back(rel);
                    issued++;
                end
                if (stream.o_vld && stream.i_rdy) begin
                    dq.push_back(stream.o_data);
                    lq.push_back(stream.o_last);
                    dr_q.push_back(rel);
                    popped++;
                end
                if (o_done) begin
                    done_cnt++;
                    done_rel = rel;
                end
                if (stall_prev) chk("stall_hold", stream.o_data, held);
                if (o_busy) chk("occupancy", (issued - popped <= 2) ? 1 : 0, 1);
                stall_prev = stream.o_vld && !stream.i_rdy;
                held = stream.o_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic start(input int base, input int num);
        @(posedge clk);
        #1;
        cs_q.delete(); ad_q.delete(); cr_q.delete();
        dq.delete(); lq.delete(); dr_q.delete();
        issued = 0;
        popped = 0;
        start_cyc = cyc;
        i_start = 1'b1;
        i_base_addr = AW'(base);
        i_num_addr = CW'(num);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic check_stream(input int base, input int num, input bit timing);
        int n;
        int a;
        n = num * NB;
        chk("cs_count", cs_q.size(), n);
        chk("word_count", dq.size(), n);
        for (int i = 0; i < n; i++) begin
            a = (base + i / NB) % 1024;
            if (i < cs_q.size()) begin
                chk("cs", cs_q[i], 128'(1) << (i % NB));
                chk("addr", ad_q[i], a);
                if (timing) chk("cs_cycle", cr_q[i], 1 + i);
            end
            if (i < dq.size()) begin
                chk("data", dq[i], exp_word(i % NB, a));
                chk("last", lq[i], (i == n - 1) ? 1 : 0);
                if (timing) chk("data_cycle", dr_q[i], 3 + i);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cs"}, o_cs, 0);
        chk({tag, "_addr"}, o_addr, 0);
        chk({tag, "_vld"}, stream.o_vld, 0);
        chk({tag, "_data"}, stream.o_data, 0);
        chk({tag, "_last"}, stream.o_last, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
    endtask

    initial begin
        int d0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single address, full throughput, exact cycle timing.
        start(0, 1);
        wait_done(40);
        check_stream(0, 1, 1);
        chk("done_cycle_n1", done_rel, 19);

        // Zero-length burst.
        start(0, 0);
        wait_done(10);
        chk("n0_cs", cs_q.size(), 0);
        chk("n0_words", dq.size(), 0);
        chk("n0_done_cycle", done_rel, 1);

        // Address wrap 1022 -> 1023 -> 0, with a stray start during READ.
        start(1022, 3);
        repeat (3) @(posedge clk);
        #1;
        i_start = 1'b1;
        i_base_addr = AW'(100);
        i_num_addr = CW'(7);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(200);
        check_stream(1022, 3, 1);
        chk("done_cycle_wrap", done_rel, 51);

        // Random back-pressure.
        rdy_mode = 1;
        start(5, 2);
        wait_done(600);
        check_stream(5, 2, 0);
        rdy_mode = 0;

        // Consumer never ready: only two reads may be outstanding.
        rdy_mode = 2;
        start(200, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("stalled_reads", issued, 2);
        chk("stalled_words", dq.size(), 0);
        rdy_mode = 0;
        wait_done(100);
        check_stream(200, 1, 0);

        // Reset in the middle of a burst, after the 7th word.
        start(300, 4);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (popped >= 7) break;
        end
        chk("pre_reset_words", popped, 7);
        #1;
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        cs_q.delete();
        dq.delete();
        #1;
        rstn = 1'b1;
        repeat (20) @(posedge clk);
        chk("post_reset_done", done_cnt, d0);
        chk("post_reset_cs", cs_q.size(), 0);
        chk("post_reset_words", dq.size(), 0);

        // Fresh burst after the abort.
        start(7, 1);
        wait_done(40);
        check_stream(7, 1, 1);
        chk("done_cycle_fresh", done_rel, 19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ifm_bank_reader.md
Name: ifm_bank_reader

Overview:
Downstream of the OFM packing/save stage. Once the 16 feature-map SRAM banks have been written, this block reads them back one 128-bit word at a time and streams the words to the next layer's compute input over a valid/ready handshake. It drives the bank chip-selects and the shared bank address, and absorbs the 1-cycle SRAM read latency. A 2-entry output FIFO gives full throughput under back-pressure.

Parameters:
NUM_BANKS, 16, number of SRAM banks; read round-robin bank 0..NUM_BANKS-1 at each address.
ADDR_W, 10, bank address width.
DATA_W, 128, bank word width.
CNT_W, 11, width of the word-count input; must hold up to 2^ADDR_W.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  asynchronous active-low reset.
i_start  in  1  one-cycle pulse; starts a burst when idle.
i_base_addr  in  ADDR_W  first bank address; sampled with i_start.
i_num_addr  in  CNT_W  number of addresses to read per bank; sampled with i_start.
o_cs  out  NUM_BANKS  one-hot bank read chip-select.
o_addr  out  ADDR_W  read address, shared by all banks.
i_rdata  in  NUM_BANKS*DATA_W  packed bank read data; bank k occupies bits [k*DATA_W +: DATA_W].
o_data  out  DATA_W  head of the output FIFO.
o_vld  out  1  o_data valid.
i_rdy  in  1  consumer ready; a transfer happens when o_vld & i_rdy.
o_last  out  1  marks the final word of the burst; qualified by o_vld.
o_busy  out  1  high from the cycle after the accepted start until the o_done cycle, inclusive.
o_done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE. Reset mid-burst aborts the burst with no o_done and discards FIFO contents.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: on i_start, latch i_base_addr and i_num_addr.
  - i_num_addr==0: go to DONE directly.
  - Otherwise: go to READ.
  - i_start while not IDLE is ignored.
- READ: a read is issued in cycle T when (fifo_count + inflight - pop_T) < 2.
  - inflight is 1 if a read was issued in T-1; pop_T = o_vld & i_rdy in T.
  - On issue: o_cs = 1<<bank_idx and o_addr = current address for exactly that cycle; otherwise o_cs = 0.
  - o_addr holds its last value when not reading.
- Data path: i_rdata is valid in T+1. The selected bank slice (using bank_idx delayed by one cycle) is written into the FIFO at the end of T+1, and is visible on o_vld/o_data in T+2.
- Counters: bank_idx increments per issue. On wrap from NUM_BANKS-1 to 0, the address increments modulo 2^ADDR_W (base+N > 1023 wraps to 0).
- After the issue of bank NUM_BANKS-1 at the final address, the FSM goes to DRAIN.
- DRAIN: no new reads. After the handshake of the last word, the FSM moves to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_busy is still 1 in this cycle.
- o_last is carried as a FIFO side bit, set only for the final issued read.
- Total words per burst = i_num_addr*NUM_BANKS, delivered in order: bank 0..15 of base, then bank 0..15 of base+1, and so on.
- Throughput: with i_rdy held high, one word per cycle after the 2-cycle start-up. i_rdy low never loses or duplicates data. The FIFO never exceeds 2 entries.
- Latency: start sampled in cycle 0; first o_cs in cycle 1; first o_vld in cycle 3.
- Simultaneous push and pop on a full FIFO cannot occur (guaranteed by the issue rule). A push and pop on a 1-entry FIFO keep the count at 1.
- o_data/o_last are stable while o_vld & !i_rdy.

Test Plan:
- Reset, then base=0, num=1, i_rdy=1.
  - o_cs walks 0x0001..0x8000 in cycles 1-16 with o_addr=0.
  - 16 words equal to bank k data appear in cycles 3-18; o_last only on word 16.
  - o_done in cycle 19.
- num=0 -> no o_cs activity; o_done one cycle after start; o_vld never asserts.
- base=1022, num=3 -> o_addr sequence 1022, 1023, 0, 16 banks each; 48 words in order.
- num=2 with i_rdy toggled pseudo-randomly (30% low) -> all 32 words received in order, none duplicated; FIFO count ≤ 2; o_data stable while stalled.
- i_rdy=0 throughout, num=1 -> exactly 2 reads issued, then o_cs=0. After i_rdy rises, the stream completes with 16 words.
- Edge cases:
  - rstn asserted mid-burst at word 7 -> all outputs 0 immediately and no o_done.
  - A fresh start after reset reads correctly.
  - i_start pulsed during READ is ignored.
